// File: rtl/spi_controller_if.sv
// Request port of the SPI frame initiator: one register command per valid/ready handshake.
interface spi_controller_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_rw;
  logic [6:0] req_addr;
  logic [7:0] req_data;

  modport master (output req_valid, req_rw, req_addr, req_data, input req_ready);
  modport slave  (input req_valid, req_rw, req_addr, req_data, output req_ready);
endinterface

// File: rtl/spi_controller.sv
// SPI mode-0 initiator: serialises {rw, addr[6:0], data[7:0]} MSB-first as one 16-bit frame
// per accepted command, with a programmable SCLK half-period and post-frame nCS gap.
module spi_controller #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_controller_if.slave  req,
  output logic             sclk,
  output logic             copi,
  output logic             ncs,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, GAP} state_t;

  localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_RELOAD = 8'(GAP_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [4:0]  bit_q, bit_d;
  logic [15:0] shift_q, shift_d;
  logic        sclk_q, sclk_d;
  logic        copi_q, copi_d;
  logic        ncs_q, ncs_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        div_zero;
  logic        framing;

  assign div_zero      = (div_q == 8'd0);
  assign req.req_ready = (state_q == IDLE);
  assign sclk          = sclk_q;
  assign copi          = copi_q;
  assign ncs           = ncs_q;
  assign busy          = busy_q;
  assign done          = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= 8'd0;
      bit_q   <= 5'd0;
      shift_q <= 16'd0;
      sclk_q  <= 1'b0;
      copi_q  <= 1'b0;
      ncs_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      sclk_q  <= sclk_d;
      copi_q  <= copi_d;
      ncs_q   <= ncs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Divider reloads on every state entry and counts down to zero within the state.
  always_comb begin
    state_d = state_q;
    div_d   = div_q - 8'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        div_d = div_q;
        if (req.req_valid) begin
          state_d = SETUP;
          div_d   = DIV_RELOAD;
          bit_d   = 5'd0;
          shift_d = {req.req_rw, req.req_addr, req.req_data};
        end
      end
      SETUP: begin
        if (div_zero) begin
          state_d = HIGH;
          div_d   = DIV_RELOAD;
        end
      end
      HIGH: begin
        if (div_zero) begin
          state_d = LOW;
          div_d   = DIV_RELOAD;
          shift_d = {shift_q[14:0], 1'b0};
          if (bit_q != 5'd16) bit_d = bit_q + 5'd1;
        end
      end
      LOW: begin
        if (div_zero) begin
          if (bit_q == 5'd16) begin
            state_d = GAP;
            div_d   = GAP_RELOAD;
          end else begin
            state_d = HIGH;
            div_d   = DIV_RELOAD;
          end
        end
      end
      GAP: begin
        if (div_zero) begin
          state_d = IDLE;
          div_d   = 8'd0;
        end
      end
      default: begin
        state_d = IDLE;
        div_d   = 8'd0;
      end
    endcase
  end

  // Outputs follow the next state so every pin is a flop aligned with its state.
  always_comb begin
    framing = (state_d == SETUP) || (state_d == HIGH) || (state_d == LOW);
    ncs_d   = !framing;
    sclk_d  = (state_d == HIGH);
    copi_d  = framing && shift_d[15];
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == GAP) && (state_q != GAP);
  end

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench: two controllers (CLK_DIV=4/GAP=8 and CLK_DIV=2/GAP=1) with a frame monitor
// and a register-peripheral model decoding completed write frames.
module tb_spi_controller;
  localparam int N = 2;
  localparam logic [1:0][7:0] DIVS = {8'd2, 8'd4};
  localparam logic [1:0][7:0] GAPS = {8'd1, 8'd8};

  typedef struct packed {
    logic [15:0]     word;
    int              rises;
    int              cur_rises;
    int              ncs_low;
    int              ncs_high;
    int              busy_len;
    int              frames;
    int              dones;
    int              done_viol;
    int              copi_viol;
    int              rise_cyc;
    int              hi_min;
    int              hi_max;
    int              lo_min;
    int              lo_max;
    logic [4:0][7:0] regs;
  } stats_t;

  typedef struct {
    int          inst;
    logic        rw;
    logic [6:0]  addr;
    logic [7:0]  data;
    logic [15:0] exp;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   valid_a = '0;
  logic [N-1:0]   rw_a = '0;
  logic [6:0]     addr_a [N];
  logic [7:0]     data_a [N];
  logic [N-1:0]   ready_a, sclk_a, copi_a, ncs_a, busy_a, done_a;
  stats_t         stats [N];
  int             cyc = 0;
  int             checks = 0;
  int             errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    spi_controller_if u_if ();
    assign u_if.req_valid = valid_a[gi];
    assign u_if.req_rw    = rw_a[gi];
    assign u_if.req_addr  = addr_a[gi];
    assign u_if.req_data  = data_a[gi];
    assign ready_a[gi]    = u_if.req_ready;

    spi_controller #(.CLK_DIV(int'(DIVS[gi])), .GAP_CYCLES(int'(GAPS[gi]))) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .req  (u_if),
      .sclk (sclk_a[gi]),
      .copi (copi_a[gi]),
      .ncs  (ncs_a[gi]),
      .busy (busy_a[gi]),
      .done (done_a[gi])
    );

    stats_t      st;
    logic        inited = 1'b0;
    logic        p_ncs = 1'b1, p_sclk = 1'b0, p_copi = 1'b0, p_busy = 1'b0;
    logic [15:0] sh = '0;
    int          run = 0, hi_run = 0, ncs_cnt = 0, busy_run = 0;

    always @(negedge clk) begin
      if (!inited) begin
        st = '0;
        st.hi_min = 9999;
        st.lo_min = 9999;
        inited = 1'b1;
      end
      if (!rst_n) begin
        sh = '0; st.cur_rises = 0; ncs_cnt = 0; busy_run = 0; run = 0;
        p_ncs = 1'b1; p_sclk = 1'b0; p_copi = 1'b0; p_busy = 1'b0;
      end else begin
        if (done_a[gi]) begin
          st.dones = st.dones + 1;
          if (!(ncs_a[gi] && !p_ncs)) st.done_viol = st.done_viol + 1;
        end else if (ncs_a[gi] && !p_ncs) begin
          st.done_viol = st.done_viol + 1;
        end
        if (!ncs_a[gi]) begin
          if (p_ncs) begin
            st.ncs_high = hi_run; sh = '0; st.cur_rises = 0; run = 0; ncs_cnt = 0;
          end
          hi_run = 0;
          ncs_cnt++;
          if (sclk_a[gi] != p_sclk) begin
            if (p_sclk) begin
              if (run < st.hi_min) st.hi_min = run;
              if (run > st.hi_max) st.hi_max = run;
            end else begin
              if (run < st.lo_min) st.lo_min = run;
              if (run > st.lo_max) st.lo_max = run;
            end
            run = 0;
          end
          run++;
          if (sclk_a[gi] && !p_sclk) begin
            sh = {sh[14:0], copi_a[gi]};
            st.cur_rises = st.cur_rises + 1;
          end
          if (sclk_a[gi] && p_sclk && (copi_a[gi] !== p_copi)) st.copi_viol = st.copi_viol + 1;
        end else begin
          hi_run++;
          if (!p_ncs) begin
            st.word = sh; st.rises = st.cur_rises; st.ncs_low = ncs_cnt;
            st.rise_cyc = cyc; st.frames = st.frames + 1;
            if (st.cur_rises == 16 && sh[15] && sh[14:8] < 7'd5) st.regs[sh[10:8]] = sh[7:0];
          end
        end
        if (busy_a[gi]) busy_run++;
        else if (p_busy) begin
          st.busy_len = busy_run; busy_run = 0;
        end
        p_ncs = ncs_a[gi]; p_sclk = sclk_a[gi]; p_copi = copi_a[gi]; p_busy = busy_a[gi];
      end
    end
    assign stats[gi] = st;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_ready(input int i, output int rdy);
    int n = 0;
    while (!ready_a[i] && n < 5000) begin tick(); n++; end
    chk("ready_timeout", 32'(ready_a[i]), 32'd1);
    rdy = cyc;
  endtask

  task automatic send(input int i, input logic rw, input logic [6:0] a, input logic [7:0] d,
                      output int hs);
    int r;
    wait_ready(i, r);
    rw_a[i] = rw; addr_a[i] = a; data_a[i] = d; valid_a[i] = 1'b1;
    tick();
    hs = cyc;
    valid_a[i] = 1'b0;
  endtask

  task automatic run_frame(input int i, input logic rw, input logic [6:0] a, input logic [7:0] d,
                           input logic [15:0] exp);
    int dv = int'(DIVS[i]);
    int gp = int'(GAPS[i]);
    int f0 = stats[i].frames;
    int d0 = stats[i].dones;
    int hs, rdy;
    send(i, rw, a, d, hs);
    chk("ncs_low_after_accept", 32'(ncs_a[i]), 32'd0);
    chk("busy_after_accept", 32'(busy_a[i]), 32'd1);
    chk("copi_bit15", 32'(copi_a[i]), 32'(exp[15]));
    wait_ready(i, rdy);
    chk("frame_word", 32'(stats[i].word), 32'(exp));
    chk("sclk_rises", stats[i].rises, 16);
    chk("ncs_low_cycles", stats[i].ncs_low, 33 * dv);
    chk("ncs_rise_time", stats[i].rise_cyc - hs, 33 * dv);
    chk("done_pulses", stats[i].dones - d0, 1);
    chk("done_with_ncs_rise", stats[i].done_viol, 0);
    chk("ready_return", rdy - hs, 33 * dv + gp);
    chk("busy_cycles", stats[i].busy_len, 33 * dv + gp);
    chk("frame_count", stats[i].frames - f0, 1);
    $display("frame inst%0d rw=%0d addr=0x%02h data=0x%02h -> word 0x%04h (expect 0x%04h)",
             i, rw, a, d, stats[i].word, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs [9];
    logic [7:0] exp_regs [5];
    int         hs, hs1, hs2, r1, r2, f0, d0, bad, n;

    vecs[0] = '{0, 1'b1, 7'h04, 8'hA5, 16'h84A5};
    vecs[1] = '{1, 1'b1, 7'h04, 8'h55, 16'h8455};
    vecs[2] = '{0, 1'b1, 7'h00, 8'h11, 16'h8011};
    vecs[3] = '{0, 1'b1, 7'h01, 8'h22, 16'h8122};
    vecs[4] = '{0, 1'b1, 7'h02, 8'h33, 16'h8233};
    vecs[5] = '{0, 1'b1, 7'h03, 8'h44, 16'h8344};
    vecs[6] = '{0, 1'b1, 7'h04, 8'h80, 16'h8480};
    vecs[7] = '{0, 1'b0, 7'h00, 8'h00, 16'h0000};
    vecs[8] = '{0, 1'b1, 7'h05, 8'h77, 16'h8577};
    exp_regs = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h80};
    for (int i = 0; i < N; i++) begin addr_a[i] = '0; data_a[i] = '0; end

    tick(); tick();
    chk("rst_ready", 32'(ready_a[0]), 32'd1);
    chk("rst_ncs", 32'(ncs_a), 32'h3);
    chk("rst_sclk", 32'(sclk_a), 32'h0);
    chk("rst_copi", 32'(copi_a), 32'h0);
    chk("rst_busy", 32'(busy_a), 32'h0);
    chk("rst_done", 32'(done_a), 32'h0);
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 9; v++)
      run_frame(vecs[v].inst, vecs[v].rw, vecs[v].addr, vecs[v].data, vecs[v].exp);

    for (int r = 0; r < 5; r++)
      chk($sformatf("reg%0d", r), 32'(stats[0].regs[r]), 32'(exp_regs[r]));
    chk("div4_high_min", stats[0].hi_min, 4);
    chk("div4_high_max", stats[0].hi_max, 4);
    chk("div2_high_min", stats[1].hi_min, 2);
    chk("div2_high_max", stats[1].hi_max, 2);
    chk("div2_low_min", stats[1].lo_min, 2);
    chk("div2_low_max", stats[1].lo_max, 2);
    chk("copi_stable_div4", stats[0].copi_viol, 0);
    chk("copi_stable_div2", stats[1].copi_viol, 0);

    // Back-to-back: valid stays high across the first frame's completion.
    wait_ready(0, r1);
    rw_a[0] = 1'b1; addr_a[0] = 7'h00; data_a[0] = 8'hFF; valid_a[0] = 1'b1;
    tick();
    hs1 = cyc;
    addr_a[0] = 7'h01; data_a[0] = 8'h3C;
    wait_ready(0, r1);
    chk("b2b_first_word", 32'(stats[0].word), 32'h80FF);
    chk("b2b_first_ready", r1 - hs1, 33 * 4 + 8);
    tick();
    hs2 = cyc;
    valid_a[0] = 1'b0;
    chk("b2b_second_accept", 32'(ready_a[0]), 32'd0);
    chk("b2b_hs_spacing", hs2 - hs1, 33 * 4 + 8 + 1);
    wait_ready(0, r2);
    chk("b2b_second_word", 32'(stats[0].word), 32'h813C);
    chk("b2b_ncs_high_gap", stats[0].ncs_high, 9);
    $display("back-to-back: 0x80FF then 0x%04h, ncs high %0d cycles", stats[0].word, stats[0].ncs_high);

    // Request inputs wiggle while busy; the frame in flight must not change.
    f0 = stats[0].frames;
    send(0, 1'b1, 7'h06, 8'h5A, hs);
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      addr_a[0] = 7'($urandom);
      data_a[0] = 8'($urandom);
      rw_a[0]   = 1'($urandom);
      valid_a[0] = k[0];
      if (ready_a[0]) bad++;
      tick();
    end
    valid_a[0] = 1'b0;
    wait_ready(0, r1);
    chk("stable_word", 32'(stats[0].word), 32'h865A);
    chk("stable_ready_low", bad, 0);
    chk("stable_frames", stats[0].frames - f0, 1);
    chk("stable_ready_time", r1 - hs, 33 * 4 + 8);
    $display("input stability: word 0x%04h, ready seen while busy %0d times", stats[0].word, bad);

    // Asynchronous reset after the 7th sclk rise.
    d0 = stats[0].dones;
    f0 = stats[0].frames;
    send(0, 1'b1, 7'h02, 8'h12, hs);
    n = 0;
    while (stats[0].cur_rises < 7 && n < 2000) begin tick(); n++; end
    chk("rst_mid_reach_rise7", stats[0].cur_rises, 7);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ncs", 32'(ncs_a[0]), 32'd1);
    chk("rst_mid_sclk", 32'(sclk_a[0]), 32'd0);
    chk("rst_mid_copi", 32'(copi_a[0]), 32'd0);
    chk("rst_mid_busy", 32'(busy_a[0]), 32'd0);
    chk("rst_mid_done", 32'(done_a[0]), 32'd0);
    tick(); tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_mid_no_done", stats[0].dones - d0, 0);
    chk("rst_mid_no_frame", stats[0].frames - f0, 0);
    chk("rst_mid_ready", 32'(ready_a[0]), 32'd1);
    $display("reset mid-frame: aborted after 7 rises, restarting frame");
    run_frame(0, 1'b1, 7'h02, 8'h12, 16'h8212);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_controller.md
# spi_controller

SPI mode-0 initiator that drives 16-bit write frames into the chip's SPI register peripheral (SCLK/COPI/nCS on ui_in[0]/[1]/[2]). It accepts one register command at a time on a valid/ready request port and serialises it MSB-first as {rw, addr[6:0], data[7:0]}. It sits in test harnesses and in on-chip or FPGA controllers that configure the output-enable, PWM-enable and duty-cycle registers.

## Interface
- CLK_DIV, 4: clk cycles per SCLK half-period; legal range 2..255. The range covers the peripheral's 2-flop input synchroniser plus its edge detector.
- GAP_CYCLES, 8: minimum nCS-high cycles after a frame; legal range 1..255.
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  command present
- req_ready  output  1  controller idle; command accepted when req_valid & req_ready
- req_rw  input  1  frame bit 15; 1 = write, 0 = no-op frame (peripheral ignores it)
- req_addr  input  7  register address, frame bits 14:8
- req_data  input  8  write data, frame bits 7:0
- sclk  output  1  SPI clock, idle low
- copi  output  1  serial data, MSB first
- ncs  output  1  chip select, active low, idle high
- busy  output  1  high from acceptance until return to IDLE
- done  output  1  one-cycle pulse when a frame completes

## Operation
- All of sclk, copi, ncs, busy and done are registered outputs. req_ready = (state == IDLE).
- Reset values: ncs=1, sclk=0, copi=0, busy=0, done=0, state=IDLE, so req_ready=1. Shift register and counters are 0.
- States are IDLE, SETUP, HIGH, LOW and GAP.
- IDLE: ncs=1, sclk=0, copi=0.
  - On handshake, latch {req_rw, req_addr, req_data} into a 16-bit shift register and go to SETUP.
  - Request inputs are ignored in every state other than IDLE.
- SETUP: lasts CLK_DIV cycles. ncs=0, sclk=0, copi=frame[15]. Then go to HIGH.
- HIGH: lasts CLK_DIV cycles with sclk=1 and copi held stable. Then go to LOW.
- LOW: lasts CLK_DIV cycles with sclk=0.
  - On entry, copi takes the next bit, or 0 after bit 0.
  - The bit counter increments on each HIGH→LOW transition.
  - After the 16th LOW, go to GAP.
- GAP: lasts GAP_CYCLES cycles.
  - On entry: ncs=1, done=1 for that one cycle only.
  - Then go to IDLE.
  - busy drops on entry to IDLE.
- Exactly 16 SCLK rising edges occur per frame, all with ncs=0.
  - copi changes only while sclk is low.
  - The last falling edge precedes the ncs rise by CLK_DIV cycles.
- The divider counter reloads at every state entry. The bit counter is 5 bits and stops at 16; no wrap-around is permitted.
- Asserting rst_n low mid-frame immediately forces the reset values (ncs=1, sclk=0), leaving the peripheral with an incomplete frame. No done pulse is produced.

## Timing
- Handshake in cycle T; at T+1: ncs=0, busy=1, copi=bit15.
- First sclk rise at T+1+CLK_DIV. Rising edge k (k=0..15) at T+1+CLK_DIV+2k·CLK_DIV.
- ncs low for exactly 33·CLK_DIV cycles; it rises at T+1+33·CLK_DIV, the same cycle done=1.
- req_ready returns at T+1+33·CLK_DIV+GAP_CYCLES.
- Back-to-back: with req_valid held high, the next handshake occurs in that first IDLE cycle. ncs is high for GAP_CYCLES+1 cycles between frames.
- Throughput: one frame per 33·CLK_DIV+GAP_CYCLES+1 cycles.

## Test plan
- Single write, CLK_DIV=4, rw=1, addr=0x04, data=0xA5:
  - bits sampled at the 16 sclk rises = 0x84A5;
  - ncs low for 132 cycles;
  - one done pulse coincident with the ncs rise;
  - busy high for 132+8 cycles.
- Back-to-back: req_valid held with (0x00,0xFF) then (0x01,0x3C) → two frames 0x80FF and 0x813C; ncs high for exactly 9 cycles between them; second handshake on the first IDLE cycle.
- Input stability: change req_addr/req_data and pulse req_valid while busy → frame bits unchanged, no extra handshake, req_ready=0 throughout.
- Reset mid-frame: assert rst_n after the 7th sclk rise → same cycle ncs=1, sclk=0, copi=0, busy=0, no done; after release req_ready=1 and a new frame 0x8212 completes normally.
- Minimum divider, CLK_DIV=2, GAP_CYCLES=1:
  - frame 0x8455 on ncs low for 66 cycles;
  - sclk high and low phases exactly 2 cycles each;
  - copi never changes while sclk=1.
- Loopback with the SPI register peripheral (CLK_DIV=4):
  - writes addr 0..4 with 0x11,0x22,0x33,0x44,0x80 → all five registers hold those values;
  - a frame with rw=0, addr=0x00, data=0x00 leaves en_reg_out_7_0 at 0x11;
  - addr 0x05 alters no register.
